muldiv_unit: RTL and testbench

//  Iterative MIPS multiply/divide unit with architectural HI/LO registers.

---
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// One shift-add or restoring-divide step per cycle, then a sign-fix cycle.
module muldiv_unit #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DWIDTH-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH-1:0] hi,
    output logic [DWIDTH-1:0] lo
);

    localparam int W  = DWIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          busy_nxt;
    logic          done_nxt;

    logic [CW-1:0] count;
    logic          is_div;
    logic          neg_a;
    logic          neg_b;
    logic          div_zero;
    logic [W-1:0]  mcand;
    logic [W-1:0]  acc_hi;
    logic [W-1:0]  acc_lo;

    logic          op_signed;
    logic [W-1:0]  abs_a;
    logic [W-1:0]  abs_b;

    logic [W:0]    mul_sum;
    logic [W-1:0]  mul_hi;
    logic [W-1:0]  mul_lo;

    logic [W:0]    div_sh;
    logic [W+1:0]  div_diff;
    logic          div_ok;
    logic [W-1:0]  div_hi;
    logic [W-1:0]  div_lo;

    logic            neg_res;
    logic [2*W-1:0]  prod;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    q_fix;
    logic [W-1:0]    r_fix;
    logic [W-1:0]    res_hi;
    logic [W-1:0]    res_lo;

    // Signed ops iterate on magnitudes; unsigned ops pass operands through.
    assign op_signed = ~op[0];
    assign abs_a = (op_signed && a[W-1]) ? -a : a;
    assign abs_b = (op_signed && b[W-1]) ? -b : b;

    // Multiply step: add multiplicand into upper half on LSB, shift right.
    assign mul_sum = {1'b0, acc_hi}
                   + (acc_lo[0] ? {1'b0, mcand} : '0);
    assign mul_hi  = mul_sum[W:1];
    assign mul_lo  = {mul_sum[0], acc_lo[W-1:1]};

    // Divide step: shift in next dividend bit, subtract if it fits.
    assign div_sh   = {acc_hi, acc_lo[W-1]};
    assign div_diff = {1'b0, div_sh} - {2'b00, mcand};
    assign div_ok   = ~div_diff[W+1];
    assign div_hi   = div_ok ? div_diff[W-1:0] : div_sh[W-1:0];
    assign div_lo   = {acc_lo[W-2:0], div_ok};

    // Sign correction applied in the FIX cycle.
    assign neg_res  = neg_a ^ neg_b;
    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_res ? -prod : prod;
    assign q_fix    = div_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
    assign r_fix    = neg_a ? -acc_hi : acc_hi;
    assign res_hi   = is_div ? r_fix : prod_fix[2*W-1:W];
    assign res_lo   = is_div ? q_fix : prod_fix[W-1:0];

    // State, busy and done registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state logic for IDLE -> CALC -> FIX -> IDLE.
    always_comb begin
        state_nxt = state;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CALC;
                    busy_nxt  = 1'b1;
                end
            end
            S_CALC: begin
                if (count == LAST) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Operand capture at start and one iteration per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            mcand    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        count    <= '0;
                        is_div   <= op[1];
                        neg_a    <= op_signed & a[W-1];
                        neg_b    <= op_signed & b[W-1];
                        div_zero <= (b == '0);
                        mcand    <= abs_b;
                        acc_hi   <= '0;
                        acc_lo   <= abs_a;
                    end
                end
                S_CALC: begin
                    count <= count + CW'(1);
                    if (is_div) begin
                        acc_hi <= div_hi;
                        acc_lo <= div_lo;
                    end else begin
                        acc_hi <= mul_hi;
                        acc_lo <= mul_lo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // HI/LO: result write in FIX, MTHI/MTLO honoured only in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == S_FIX) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (state == S_IDLE) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table plus
// hand-written busy/done/reset sequences, results via scoreboard.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    vec_t tbl[$];
    res_t sb[$];

    muldiv_unit #(.DWIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint p;
        int     q;
        int     r;
        case (o)
            2'd0: begin
                p = longint'(signed'(x)) * longint'(signed'(y));
                return 64'(p);
            end
            2'd1: return {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF)
                    return {32'd0, 32'h80000000};
                q = signed'(x) / signed'(y);
                r = signed'(x) % signed'(y);
                return {32'(r), 32'(q)};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    task automatic wait_done(output int cyc, output int bcnt);
        res_t r;
        cyc  = 0;
        bcnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (busy) bcnt++;
        end
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got 1 want 0");
            end else begin
                r = sb.pop_front();
                check("hi_result", hi, r.hi);
                check("lo_result", lo, r.lo);
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end else begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got 0 want 1 within 60");
            if (sb.size() != 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        int   cyc;
        int   bcnt;
        logic seen;
        vec_t v;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;

        tbl.push_back('{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                        32'hFFFFFFFE, 32'h00000001});
        tbl.push_back('{2'd0, 32'hFFFFFFFD, 32'd5,
                        32'hFFFFFFFF, 32'hFFFFFFF1});
        tbl.push_back('{2'd0, 32'h80000000, 32'h80000000,
                        32'h40000000, 32'h00000000});
        tbl.push_back('{2'd2, 32'hFFFFFFF9, 32'd2,
                        32'hFFFFFFFF, 32'hFFFFFFFD});
        tbl.push_back('{2'd3, 32'd7, 32'd2, 32'd1, 32'd3});
        tbl.push_back('{2'd2, 32'd7, 32'hFFFFFFFE,
                        32'd1, 32'hFFFFFFFD});
        tbl.push_back('{2'd3, 32'h1234, 32'd0,
                        32'h1234, 32'hFFFFFFFF});
        tbl.push_back('{2'd2, 32'h80000000, 32'hFFFFFFFF,
                        32'd0, 32'h80000000});
        tbl.push_back('{2'd2, 32'hFFFFFFFB, 32'd0,
                        32'hFFFFFFFB, 32'hFFFFFFFF});
        for (int i = 0; i < 8; i++) begin
            logic [63:0] m;
            v.op = 2'(i % 4);
            v.a  = $urandom;
            v.b  = $urandom;
            if (i >= 4) v.b = v.b >> $urandom_range(28, 8);
            m     = model(v.op, v.a, v.b);
            v.ehi = m[63:32];
            v.elo = m[31:0];
            tbl.push_back(v);
        end

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            start = 1'b1;
            op    = tbl[i].op;
            a     = tbl[i].a;
            b     = tbl[i].b;
            sb.push_back('{tbl[i].ehi, tbl[i].elo});
            @(negedge clk);
            start = 1'b0;
            a     = $urandom;
            b     = $urandom;
            wait_done(cyc, bcnt);
            check("latency", 32'(cyc), 32'd33);
            check("busy_cycles", 32'(bcnt + 1), 32'd33);
        end

        start = 1'b1;
        op    = 2'd1;
        a     = 32'd6;
        b     = 32'd7;
        hi_we = 1'b1;
        wdata = 32'h11111111;
        sb.push_back('{32'd0, 32'd42});
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        check("mthi_with_start", hi, 32'h11111111);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 2'd3;
        a     = 32'd100;
        b     = 32'd3;
        hi_we = 1'b1;
        wdata = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        check("mthi_busy", hi, 32'h11111111);
        wait_done(cyc, bcnt);
        check("ignored_start_latency", 32'(cyc), 32'd28);

        start = 1'b1;
        op    = 2'd3;
        a     = 32'd100;
        b     = 32'd3;
        sb.push_back('{32'd1, 32'd33});
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcnt);
        check("done_cycle_start", 32'(cyc + 1), 32'd34);

        start = 1'b1;
        op    = 2'd1;
        a     = 32'hFFFFFFFF;
        b     = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("no_done_after_rst", {31'd0, seen}, 32'd0);

        lo_we = 1'b1;
        wdata = 32'hA5A5A5A5;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", lo, 32'hA5A5A5A5);
        check("mtlo_hi_kept", hi, 32'd0);
        @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
